// File: rtl/nco_meter.sv
// -----------------------------------------------------------------------------
// nco_meter
//
// Recovers frequency and relative phase from a pair of offset-binary sample
// streams, typically the sin/cos outputs of an NCO looped back for checking,
// or the digitised outputs of an ADC.
//
//   * Each channel has a hysteresis zero-crossing detector that produces a
//     one-cycle rising event on every LO->HI transition.
//   * Frequency: rising ref events are counted over a fixed gate of
//     GATE_CYCLES clocks. With a 1 s gate the result is directly in Hz.
//   * Phase: the delay D from a ref event to the following mea event and the
//     ref period P are measured in clocks, and floor(100*D/P) is computed
//     with a 7-step restoring divider, giving a percentage 0..99.
//   * sig_lost flags a ref channel that has stopped toggling.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           measurement enable; low holds everything cleared except
//                the two result registers
//   ref_in       reference channel samples (sin_out), offset binary
//   mea_in       measured channel samples (cos_out), offset binary
//   freq_out     ref rising edges counted in the last complete gate
//   freq_valid   one-cycle pulse when freq_out updates
//   phase_out    floor(100*D/P), 0..99
//   phase_valid  one-cycle pulse when phase_out updates
//   sig_lost     no ref edge for 2^PER_W-1 clocks
// -----------------------------------------------------------------------------
module nco_meter #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int DATA_WIDTH    = 16,
    parameter int GATE_CYCLES   = CLK_FREQUENCY,
    parameter int HYST          = 256,
    parameter int PER_W         = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ref_in,
    input  logic [DATA_WIDTH-1:0] mea_in,
    output logic [23:0]           freq_out,
    output logic                  freq_valid,
    output logic [6:0]            phase_out,
    output logic                  phase_valid,
    output logic                  sig_lost
);

    // Thresholds are one bit wider than the samples so MID+HYST cannot wrap.
    localparam logic [DATA_WIDTH:0] MID   = {2'b01, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH:0] HI_TH = MID + (DATA_WIDTH+1)'(HYST);
    localparam logic [DATA_WIDTH:0] LO_TH = MID - (DATA_WIDTH+1)'(HYST);

    localparam int                 GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // D*100 needs 7 more bits than D, since 100 < 128.
    localparam int                 DIV_W    = PER_W + 7;
    localparam logic [PER_W-1:0]   PER_MAX  = '1;
    localparam logic [23:0]        EDGE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DIVIDE,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    // Crossing detector state and events
    logic ref_hi;
    logic ref_evt;
    logic mea_hi;
    logic mea_evt;
    logic ref_above;
    logic ref_below;
    logic mea_above;
    logic mea_below;

    // Frequency gate
    logic [GATE_W-1:0] gate_cnt;
    logic [23:0]       edge_cnt;
    logic [23:0]       edge_next;

    // Period / delay measurement
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] d_lat;
    logic             mea_seen;

    // Divider
    logic [DIV_W-1:0] d_ext;
    logic [DIV_W-1:0] p_ext;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] div_sh;
    logic [6:0]       quot;
    logic [2:0]       div_cnt;

    // FSM decode
    logic start_div;
    logic set_lost;

    assign ref_above = ({1'b0, ref_in} >= HI_TH);
    assign ref_below = ({1'b0, ref_in} <= LO_TH);
    assign mea_above = ({1'b0, mea_in} >= HI_TH);
    assign mea_below = ({1'b0, mea_in} <= LO_TH);

    // Hysteresis detectors. Samples strictly between the two thresholds leave
    // the state alone, which keeps noise around mid-scale from producing
    // spurious edges. The event is registered, so it appears one clock after
    // the sample that crossed the upper threshold.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            ref_hi  <= 1'b0;
            ref_evt <= 1'b0;
            mea_hi  <= 1'b0;
            mea_evt <= 1'b0;
        end else begin
            ref_evt <= !ref_hi && ref_above;
            mea_evt <= !mea_hi && mea_above;

            if (!ref_hi && ref_above) begin
                ref_hi <= 1'b1;
            end else if (ref_hi && ref_below) begin
                ref_hi <= 1'b0;
            end

            if (!mea_hi && mea_above) begin
                mea_hi <= 1'b1;
            end else if (mea_hi && mea_below) begin
                mea_hi <= 1'b0;
            end
        end
    end

    // Saturating edge count, including an event in the current cycle so the
    // last gate cycle is not lost when the count is published.
    assign edge_next = (ref_evt && (edge_cnt != EDGE_MAX)) ? edge_cnt + 24'd1 : edge_cnt;

    // Frequency gate. The published count is taken from edge_next on the
    // last gate cycle; the edge counter then restarts from zero so an event
    // on gate cycle 0 belongs to the new gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
        end else if (!en) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (gate_cnt == GATE_LAST) begin
                freq_out   <= edge_next;
                freq_valid <= 1'b1;
                edge_cnt   <= '0;
                gate_cnt   <= '0;
            end else begin
                edge_cnt <= edge_next;
                gate_cnt <= gate_cnt + 1'b1;
            end
        end
    end

    // Period tracking runs in every state so that the ref edge closing a
    // dropped pair still starts the next period. per_cnt is loaded with 1 on
    // a ref event, so it always equals the number of clocks since that event.
    // A mea event coinciding with the ref event belongs to the new period
    // with D=0. Before the first ref edge (IDLE) mea events are ignored.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            per_cnt  <= '0;
            d_lat    <= '0;
            mea_seen <= 1'b0;
        end else if (ref_evt) begin
            per_cnt  <= PER_W'(1);
            d_lat    <= '0;
            mea_seen <= mea_evt;
        end else begin
            if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end
            if (mea_evt && !mea_seen && (state != IDLE)) begin
                d_lat    <= per_cnt;
                mea_seen <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. A period closes on a ref event; a result is only
    // computed if a mea event was seen within it. Pairs closing while the
    // divider is busy are simply ignored here.
    always_comb begin
        state_next = state;
        start_div  = 1'b0;
        set_lost   = 1'b0;

        unique case (state)
            IDLE: begin
                if (ref_evt) begin
                    state_next = ARMED;
                end else if (per_cnt == PER_MAX) begin
                    set_lost = 1'b1;
                end
            end
            ARMED: begin
                if (ref_evt) begin
                    if (mea_seen && (d_lat < per_cnt)) begin
                        start_div  = 1'b1;
                        state_next = DIVIDE;
                    end
                end else if (per_cnt == PER_MAX) begin
                    set_lost   = 1'b1;
                    state_next = IDLE;
                end
            end
            DIVIDE: begin
                if (div_cnt == 3'd6) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                state_next = ARMED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Loss-of-signal flag: set on per_cnt saturation, cleared by any ref edge.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sig_lost <= 1'b0;
        end else if (ref_evt) begin
            sig_lost <= 1'b0;
        end else if (set_lost) begin
            sig_lost <= 1'b1;
        end
    end

    // D*100 as shifts and adds (64+32+4).
    assign d_ext    = DIV_W'(d_lat);
    assign p_ext    = DIV_W'(per_cnt);
    assign dividend = (d_ext << 6) + (d_ext << 5) + (d_ext << 2);

    // Restoring divider. Because D < P the quotient is below 100, so only
    // seven quotient bits exist; the divisor starts at P<<6 and is shifted
    // right each step, producing the quotient MSB first in exactly 7 cycles.
    // The result register and valid pulse are written in OUT, giving a
    // 9-clock latency from the closing ref event.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            div_sh      <= '0;
            quot        <= '0;
            div_cnt     <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
        end else if (!en) begin
            rem         <= '0;
            div_sh      <= '0;
            quot        <= '0;
            div_cnt     <= '0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= 1'b0;
            if (start_div) begin
                rem     <= dividend;
                div_sh  <= p_ext << 6;
                quot    <= '0;
                div_cnt <= '0;
            end else if (state == DIVIDE) begin
                if (rem >= div_sh) begin
                    rem  <= rem - div_sh;
                    quot <= {quot[5:0], 1'b1};
                end else begin
                    quot <= {quot[5:0], 1'b0};
                end
                div_sh  <= div_sh >> 1;
                div_cnt <= div_cnt + 3'd1;
            end

            if (state == OUT) begin
                phase_out   <= quot;
                phase_valid <= 1'b1;
            end
        end
    end

endmodule
